// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    localparam int LINE_ADDR_LEN_DEF = 2;
    localparam int SET_ADDR_LEN_DEF  = 2;
    localparam int LINE_W_DEF        = 32 << LINE_ADDR_LEN_DEF;
    localparam int TAG_ADDR_LEN_DEF  = 32 - 2 - LINE_ADDR_LEN_DEF - SET_ADDR_LEN_DEF;

    function automatic logic [31:0] word_field(input logic [31:0] addr, input int line_len);
        return (addr >> 2) & ((32'd1 << line_len) - 32'd1);
    endfunction

    function automatic logic [31:0] set_field(input logic [31:0] addr, input int line_len,
                                              input int set_len);
        return (addr >> (2 + line_len)) & ((32'd1 << set_len) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_field(input logic [31:0] addr, input int line_len,
                                              input int set_len);
        return addr >> (2 + line_len + set_len);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Line-wide memory bus between the cache controller (master) and main memory (slave).
interface dcache_ctrl_if #(
    parameter int LINE_W = 128
);
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wline;
    logic [LINE_W-1:0] mem_rline;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wline,
                    input  mem_rline, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wline,
                    output mem_rline, mem_ack);
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache; hits are combinational, misses
// stall the pipeline while the FSM writes back a dirty victim and refills the line.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rd_req,
    input  logic           wr_req,
    input  logic [31:0]    addr,
    input  logic [31:0]    wr_data,
    input  logic [3:0]     wr_be,
    output logic [31:0]    rd_data,
    output logic           miss,
    output logic [31:0]    miss_count,
    dcache_ctrl_if.master  mem
);
    localparam int SETS         = 1 << SET_ADDR_LEN;
    localparam int LINE_W       = 32 << LINE_ADDR_LEN;
    localparam int OFF_W        = LINE_ADDR_LEN + 2;
    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;

    logic [LINE_ADDR_LEN-1:0] word_s;
    logic [SET_ADDR_LEN-1:0]  set_s;
    logic [TAG_ADDR_LEN-1:0]  tag_s;
    logic                     req_s;
    logic                     hit_s;
    logic                     wr_hit_s;
    logic [LINE_W-1:0]        wr_line_s;

    state_e                   state_q;
    logic [SETS-1:0]          valid_q;
    logic [SETS-1:0]          dirty_q;
    logic [TAG_ADDR_LEN-1:0]  tag_arr_q  [SETS];
    logic [LINE_W-1:0]        data_arr_q [SETS];
    logic [TAG_ADDR_LEN-1:0]  tag_lat_q;
    logic [SET_ADDR_LEN-1:0]  set_lat_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [31:0]              mem_addr_q;
    logic [LINE_W-1:0]        mem_wline_q;
    logic [31:0]              miss_count_q;

    assign word_s = LINE_ADDR_LEN'(word_field(addr, LINE_ADDR_LEN));
    assign set_s  = SET_ADDR_LEN'(set_field(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign tag_s  = TAG_ADDR_LEN'(tag_field(addr, LINE_ADDR_LEN, SET_ADDR_LEN));

    assign req_s    = rd_req | wr_req;
    assign hit_s    = req_s & valid_q[set_s] & (tag_arr_q[set_s] == tag_s);
    // Writes only land while the pipeline is not stalled.
    assign wr_hit_s = (state_q == IDLE) & wr_req & hit_s;

    assign miss       = (state_q != IDLE) | (req_s & ~hit_s);
    assign rd_data    = data_arr_q[set_s][32*word_s +: 32];
    assign miss_count = miss_count_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wline = mem_wline_q;

    // Byte-lane merge of store data into the addressed line.
    always_comb begin
        wr_line_s = data_arr_q[set_s];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                wr_line_s[32*word_s + 8*b +: 8] = wr_data[8*b +: 8];
            end else begin
                wr_line_s[32*word_s + 8*b +: 8] = data_arr_q[set_s][32*word_s + 8*b +: 8];
            end
        end
    end

    // Tag and data storage: refill installs a whole line, a write hit updates selected bytes.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem.mem_ack) begin
            data_arr_q[set_lat_q] <= mem.mem_rline;
            tag_arr_q[set_lat_q]  <= tag_lat_q;
        end else if (wr_hit_s) begin
            data_arr_q[set_s] <= wr_line_s;
        end
    end

    // Miss-handling FSM with registered memory-bus outputs and line state bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            tag_lat_q    <= '0;
            set_lat_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wline_q  <= '0;
            miss_count_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_hit_s) begin
                        dirty_q[set_s] <= 1'b1;
                    end
                    if (req_s && !hit_s) begin
                        miss_count_q <= miss_count_q + 32'd1;
                        tag_lat_q    <= tag_s;
                        set_lat_q    <= set_s;
                        mem_req_q    <= 1'b1;
                        if (valid_q[set_s] && dirty_q[set_s]) begin
                            state_q     <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_arr_q[set_s], set_s, {OFF_W{1'b0}}};
                            mem_wline_q <= data_arr_q[set_s];
                        end else begin
                            state_q    <= REFILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {tag_s, set_s, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    // Request stays high: the refill is presented the cycle after the ack.
                    if (mem.mem_ack) begin
                        dirty_q[set_lat_q] <= 1'b0;
                        mem_we_q           <= 1'b0;
                        mem_addr_q         <= {tag_lat_q, set_lat_q, {OFF_W{1'b0}}};
                        state_q            <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem.mem_ack) begin
                        valid_q[set_lat_q] <= 1'b1;
                        dirty_q[set_lat_q] <= 1'b0;
                        mem_req_q          <= 1'b0;
                        state_q            <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and line-wide main memory.
- Drives the miss/stall request that the hazard unit consumes as DCacheMiss.
- Hits complete in zero cycles. A miss stalls the pipeline while an FSM writes back a dirty victim, then refills the line over a req/ack memory handshake.

Parameters:
- LINE_ADDR_LEN, 2, log2(words per line); default gives 4 words = 128-bit line.
- SET_ADDR_LEN, 2, log2(number of sets); default gives 4 sets.
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN, tag width (derived; do not override).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  load in MEM stage.
- wr_req  in  1  store in MEM stage.
- addr  in  32  byte address; bits [1:0] ignored (word access).
- wr_data  in  32  store data, already lane-aligned.
- wr_be  in  4  byte enables for the store.
- rd_data  out  32  load data; valid when miss=0 and rd_req=1.
- miss  out  1  stall request to the hazard unit (DCacheMiss).
- miss_count  out  32  number of misses detected since reset, wraps.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = line write-back, 0 = line read.
- mem_addr  out  32  line-aligned byte address.
- mem_wline  out  32<<LINE_ADDR_LEN  victim line data.
- mem_rline  in  32<<LINE_ADDR_LEN  refill line data; sampled on mem_ack.
- mem_ack  in  1  one-cycle pulse; ends the current transaction.

Behaviour:
- Address split:
  - word = addr[LINE_ADDR_LEN+1:2]
  - set = next SET_ADDR_LEN bits
  - tag = remaining upper bits
- hit = (rd_req|wr_req) & valid[set] & (tag_arr[set]==tag).
- Reset: async clear of all valid and dirty bits, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, miss_count=0. Tag and data arrays are not cleared. Any in-flight memory transaction is abandoned.
- miss is combinational: (state!=IDLE) | ((rd_req|wr_req) & ~hit).
- Read hit: rd_data is combinational from the data array the same cycle; no state change.
- Write hit: selected bytes update at the clock edge; dirty[set] is set.
- rd_req and wr_req both high: treated as a write; rd_data still shows the pre-write word.
- FSM IDLE:
  - On miss with a request present, miss_count increments by 1 (exactly once per miss).
  - If valid & dirty at the victim: go to WRITEBACK. mem_req=1, mem_we=1, mem_addr={tag_arr[set],set,0}, mem_wline=victim line.
  - Otherwise: go to REFILL. mem_req=1, mem_we=0, mem_addr={tag,set,0}.
  - mem_ack in IDLE is ignored.
- FSM WRITEBACK:
  - mem_req, mem_we, mem_addr and mem_wline are held stable until mem_ack.
  - On mem_ack: dirty[set]=0, issue the refill request the next cycle, go to REFILL.
- FSM REFILL:
  - mem_req held with mem_we=0 until mem_ack.
  - On mem_ack: data[set]=mem_rline, tag_arr[set]=captured tag, valid=1, dirty=0, mem_req=0, go to IDLE.
- Request address capture:
  - The request address is latched on miss entry; the refill uses the latched address.
  - The CPU is required to hold the request while miss=1.
  - If the request drops mid-miss, the refill still completes.
- Latency:
  - Clean miss: miss rises in the detection cycle (C0); mem_req is high from C1; ack in cycle Ca; miss is 0 in Ca+1, where the access hits.
  - Dirty miss adds the write-back round trip plus 1 cycle.
- A write miss allocates the line, then performs the write as a hit in the cycle miss drops.
- Reset mid-operation:
  - mem_req drops asynchronously.
  - miss follows the combinational rule; with a request present after reset, it is a miss.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, REFILL}
  - LINE_ADDR_LEN/SET_ADDR_LEN defaults
  - localparams for line width and tag width
  - address-field extraction functions
- Tag/valid/dirty/data arrays and the FSM stay in one module; no RTL sub-module.
- The bench uses a separate behavioural memory model, mem_line_model, with configurable ack latency.

Test Plan:
- Cold read miss, then fill:
  - Stimulus: after reset, rd_req addr=0x100; memory returns line words {0x44444444,0x33333333,0x22222222,0x11111111} (word0 last) after 3 cycles.
  - Required: miss=1 in C0; mem_req=1, mem_we=0, mem_addr=0x100 from C1; miss=0 the cycle after ack; rd_data=0x11111111; miss_count=1.
- Read hit:
  - Stimulus: rd_req addr=0x104.
  - Required: miss=0 the same cycle; rd_data=0x22222222; mem_req stays 0.
- Byte write hit:
  - Stimulus: wr_req addr=0x100, wr_be=4'b0010, wr_data=0x0000AB00.
  - Required: miss=0; a following read of 0x100 returns 0x1111AB11.
- Dirty eviction:
  - Stimulus: rd_req addr=0x140 (same set 0).
  - Required: write-back with mem_we=1, mem_addr=0x100, mem_wline word0=0x1111AB11; after ack, refill with mem_we=0, mem_addr=0x140; miss_count=2.
- Reset mid-refill:
  - Stimulus: rst_n low while mem_req=1 in REFILL.
  - Required: mem_req=0 immediately; miss_count=0; after release, rd 0x104 misses (valid cleared).
- Stray ack and rd+wr collision:
  - Stimulus: mem_ack pulse in IDLE; then rd_req=wr_req=1 on a hit address.
  - Required: the ack causes no state change; the collision performs the write and sets dirty.
